hpi_burst_ctrl: RTL
===================

Name: hpi_burst_ctrl

Overview:
- Hardware master for the CY7C67200 EZ-OTG Host Port Interface (HPI). It replaces software bit-banging of the HPI PIO lines.
- Accepts single-register or burst memory commands from a NIOS-side Avalon/PIO wrapper.
- Generates correctly timed active-low CS/R/W/RESET strobes with configurable setup, strobe and hold widths.
- Streams burst data through valid/ready ports; burst mode uses the chip's address auto-increment.

Parameters:
- DATA_W, 16, HPI data bus width.
- LEN_W, 8, width of the burst length field in words.
- SETUP_CYC, 2, cycles with CS low and address/data stable before the strobe; range 1..15.
- STROBE_CYC, 4, cycles R or W is held low; range 1..15.
- HOLD_CYC, 2, recovery cycles with all strobes high after each access; range 1..15.
- RESET_CYC, 64, cycles otg_hpi_reset is held low for a chip reset; range 1..65535.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller accepts a command when high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_burst  in  1  1 = burst memory access, 0 = single register access.
- cmd_reg  in  2  HPI register for a single access: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- cmd_mem_addr  in  DATA_W  chip memory address for a burst.
- cmd_len  in  LEN_W  number of data words in a burst; 0 is allowed.
- chip_rst_req  in  1  one-cycle request for a chip reset.
- wr_data  in  DATA_W  write stream data.
- wr_valid  in  1  write stream valid.
- wr_ready  out  1  write stream ready.
- rd_data  out  DATA_W  read stream data.
- rd_valid  out  1  read stream valid.
- rd_ready  in  1  read stream ready.
- busy  out  1  high whenever the controller is not IDLE.
- done  out  1  one-cycle pulse when a command or chip reset completes.
- otg_hpi_address  out  2  HPI register select.
- otg_hpi_data_in  in  DATA_W  data from the chip.
- otg_hpi_data_out  out  DATA_W  data to the chip; the top level enables its tristate driver while otg_hpi_w is low.
- otg_hpi_r  out  1  active-low read strobe.
- otg_hpi_w  out  1  active-low write strobe.
- otg_hpi_cs  out  1  active-low chip select.
- otg_hpi_reset  out  1  active-low chip reset.

Behaviour:
- Reset values: cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, otg_hpi_r/w/cs/reset=1, otg_hpi_address=0, otg_hpi_data_out=0. cmd_ready rises in the first cycle after reset deasserts.
- Reset asserted mid-operation aborts the operation at the next clock edge. All outputs return to their reset values, and any half-completed strobe ends immediately.
- States: IDLE, CHIP_RST, SETUP, STROBE, HOLD. All HPI outputs are registered.
- IDLE: cmd_ready=1.
  - If chip_rst_req is high, enter CHIP_RST; chip_rst_req has priority over a simultaneous cmd_valid.
  - Otherwise a cmd_valid&cmd_ready handshake latches the command.
- CHIP_RST: otg_hpi_reset=0 for exactly RESET_CYC cycles, then done pulses and the controller returns to IDLE.
- Access sequence:
  - Single access: one beat to cmd_reg.
  - Burst: an address beat that writes cmd_mem_addr to register 2, followed by cmd_len data beats on register 0.
  - cmd_len=0: the burst performs only the address beat, then done.
  - cmd_write and cmd_len are ignored for the address beat; it is always a write.
- Each beat passes through SETUP, STROBE and HOLD:
  - SETUP: cs=0 and address driven for SETUP_CYC cycles.
  - Write data beat: SETUP holds (timer frozen) until wr_valid. wr_ready=1 for exactly the capture cycle; wr_data is latched into otg_hpi_data_out.
  - STROBE: r=0 or w=0 for STROBE_CYC cycles. Read data is sampled from otg_hpi_data_in on the last STROBE cycle.
  - HOLD: cs=1, r=1, w=1 for HOLD_CYC cycles.
- Read data handling:
  - At the end of STROBE the sampled word is loaded into rd_data and rd_valid is set.
  - If rd_valid is already high and rd_ready is low (previous word not yet taken), the controller stays in STROBE with the strobe still asserted and re-samples each cycle until the output slot frees. Software must keep rd_ready high to meet chip read timing.
  - rd_valid clears on rd_valid&rd_ready when no new word is loaded in the same cycle.
- Completion: after the HOLD of the final beat, done=1 for one cycle and the controller enters IDLE. cmd_ready returns to 1 in the same cycle done pulses.
- Beat count uses an LEN_W-bit down-counter. cmd_len=2^LEN_W-1 executes that many beats with no wrap-around.
- Beat duration with no stalls: SETUP_CYC+STROBE_CYC+HOLD_CYC cycles.
- cmd_valid while busy is ignored; cmd_ready is 0.
- wr_valid outside a write data SETUP is ignored.

Test Plan:
1. Reset then chip_rst_req with RESET_CYC=64 -> otg_hpi_reset low for exactly 64 cycles, done pulses once, busy is 0 afterwards.
2. Single write: reg=1, wr_data=0xBEEF -> address=1, cs low for 2 setup cycles, w low 4 cycles with data_out=0xBEEF, cs/w high 2 cycles, done pulses; the complete command takes 8 cycles.
3. Burst write to addr 0x1000, len=3, data 0x0001/0x0002/0x0003, wr_valid withheld 5 cycles before the second word -> address beat writes 0x1000 to reg 2, then three writes to reg 0 in order, SETUP stretched by 5 cycles, done pulses once.
4. Burst read from 0x2000, len=2, chip model returns 0xAAAA then 0x5555, rd_ready low for 10 cycles at the first word -> rd_data sequence 0xAAAA, 0x5555, no words lost or duplicated, second STROBE extended while rd_valid is pending.
5. Burst with len=0 -> only the address beat occurs, wr_ready never asserts, done pulses.
6. reset_reset asserted during the STROBE of beat 2 of a len=4 write -> next cycle w/cs/r=1, busy=0, rd_valid=0; a new single read afterwards completes normally.

Source files
------------

// File: rtl/hpi_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hpi_burst_ctrl
// Brief   : Hardware master for the CY7C67200 Host Port Interface. Runs
//           single-register and auto-incrementing burst accesses with timed
//           active-low CS/R/W strobes, plus a timed chip reset pulse.
// Revision: 1.0 - initial release
// ============================================================================
module hpi_burst_ctrl #(
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int RESET_CYC  = 64
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_burst,
  input  logic [1:0]        cmd_reg,
  input  logic [DATA_W-1:0] cmd_mem_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              chip_rst_req,
  // write stream
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  // read stream
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  // status
  output logic              busy,
  output logic              done,
  // HPI pins
  output logic [1:0]        otg_hpi_address,
  input  logic [DATA_W-1:0] otg_hpi_data_in,
  output logic [DATA_W-1:0] otg_hpi_data_out,
  output logic              otg_hpi_r,
  output logic              otg_hpi_w,
  output logic              otg_hpi_cs,
  output logic              otg_hpi_reset
);

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] STROBE_LD = TMR_W'(STROBE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] RESET_LD  = TMR_W'(RESET_CYC - 1);
  localparam logic [1:0]       REG_DATA  = 2'd0;
  localparam logic [1:0]       REG_ADDR  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHIP_RST = 3'd1,
    S_SETUP    = 3'd2,
    S_STROBE   = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;        // counts down to 0 within a phase
  logic [LEN_W-1:0]   beats_left, beats_nxt;   // data beats still to run after this one
  logic               is_write, is_write_nxt;  // direction of the command's data beats
  logic               beat_write, beat_write_nxt; // direction of the current beat
  logic               have_data, have_data_nxt;   // current beat needs no stream word
  logic [1:0]         addr_nxt;
  logic [DATA_W-1:0]  dout_nxt;
  logic [DATA_W-1:0]  rd_data_nxt;
  logic               rd_valid_nxt;
  logic               done_nxt;
  logic               ready_nxt;
  logic               cs_nxt, r_nxt, w_nxt, hrst_nxt;

  assign busy = (state != S_IDLE);

  // Next-state, datapath and registered-pin values; wr_ready is the only combinational output.
  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    beats_nxt      = beats_left;
    is_write_nxt   = is_write;
    beat_write_nxt = beat_write;
    have_data_nxt  = have_data;
    addr_nxt       = otg_hpi_address;
    dout_nxt       = otg_hpi_data_out;
    rd_data_nxt    = rd_data;
    rd_valid_nxt   = rd_valid & ~rd_ready;
    done_nxt       = 1'b0;
    wr_ready       = 1'b0;

    case (state)
      S_IDLE: begin
        if (chip_rst_req) begin
          state_nxt = S_CHIP_RST;
          timer_nxt = RESET_LD;
        end else if (cmd_valid && cmd_ready) begin
          state_nxt    = S_SETUP;
          timer_nxt    = SETUP_LD;
          is_write_nxt = cmd_write;
          if (cmd_burst) begin
            // Address beat: always a write of the start address, data already known.
            addr_nxt       = REG_ADDR;
            dout_nxt       = cmd_mem_addr;
            beat_write_nxt = 1'b1;
            have_data_nxt  = 1'b1;
            beats_nxt      = cmd_len;
          end else begin
            addr_nxt       = cmd_reg;
            beat_write_nxt = cmd_write;
            have_data_nxt  = ~cmd_write;
            beats_nxt      = '0;
          end
        end
      end

      S_CHIP_RST: begin
        if (timer == '0) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end

      S_SETUP: begin
        // A write beat waits here with the timer frozen until its stream word arrives.
        if (!have_data) begin
          wr_ready = wr_valid;
          if (wr_valid) begin
            have_data_nxt = 1'b1;
            dout_nxt      = wr_data;
          end
        end
        if (have_data || wr_valid) begin
          if (timer == '0) begin
            state_nxt = S_STROBE;
            timer_nxt = STROBE_LD;
          end else begin
            timer_nxt = timer - TMR_W'(1);
          end
        end
      end

      S_STROBE: begin
        if (timer != '0) begin
          timer_nxt = timer - TMR_W'(1);
        end else if (beat_write) begin
          state_nxt = S_HOLD;
          timer_nxt = HOLD_LD;
        end else if (!rd_valid || rd_ready) begin
          // Output slot is free (or frees this cycle): take the word now.
          rd_data_nxt  = otg_hpi_data_in;
          rd_valid_nxt = 1'b1;
          state_nxt    = S_HOLD;
          timer_nxt    = HOLD_LD;
        end
      end

      S_HOLD: begin
        if (timer != '0) begin
          timer_nxt = timer - TMR_W'(1);
        end else if (beats_left != '0) begin
          // Next burst beat goes to the DATA register; the chip auto-increments.
          beats_nxt      = beats_left - LEN_W'(1);
          state_nxt      = S_SETUP;
          timer_nxt      = SETUP_LD;
          addr_nxt       = REG_DATA;
          beat_write_nxt = is_write;
          have_data_nxt  = ~is_write;
        end else begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Pins are registered from the next state so they line up with the state register.
    cs_nxt    = ~((state_nxt == S_SETUP) || (state_nxt == S_STROBE));
    r_nxt     = ~((state_nxt == S_STROBE) && !beat_write_nxt);
    w_nxt     = ~((state_nxt == S_STROBE) && beat_write_nxt);
    hrst_nxt  = ~(state_nxt == S_CHIP_RST);
    ready_nxt = (state_nxt == S_IDLE);
  end

  // State and output registers with synchronous reset that aborts any access.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state            <= S_IDLE;
      timer            <= '0;
      beats_left       <= '0;
      is_write         <= 1'b0;
      beat_write       <= 1'b0;
      have_data        <= 1'b0;
      cmd_ready        <= 1'b0;
      done             <= 1'b0;
      rd_data          <= '0;
      rd_valid         <= 1'b0;
      otg_hpi_address  <= '0;
      otg_hpi_data_out <= '0;
      otg_hpi_cs       <= 1'b1;
      otg_hpi_r        <= 1'b1;
      otg_hpi_w        <= 1'b1;
      otg_hpi_reset    <= 1'b1;
    end else begin
      state            <= state_nxt;
      timer            <= timer_nxt;
      beats_left       <= beats_nxt;
      is_write         <= is_write_nxt;
      beat_write       <= beat_write_nxt;
      have_data        <= have_data_nxt;
      cmd_ready        <= ready_nxt;
      done             <= done_nxt;
      rd_data          <= rd_data_nxt;
      rd_valid         <= rd_valid_nxt;
      otg_hpi_address  <= addr_nxt;
      otg_hpi_data_out <= dout_nxt;
      otg_hpi_cs       <= cs_nxt;
      otg_hpi_r        <= r_nxt;
      otg_hpi_w        <= w_nxt;
      otg_hpi_reset    <= hrst_nxt;
    end
  end

endmodule
`default_nettype wire
